// File: rtl/ysyx_23060184_lsu_pkg.sv
// Shared LSU definitions: control-field widths, size/extend codes, FSM states and
// the helpers that decode a store mask or load opcode into an access size.
package ysyx_23060184_lsu_pkg;

    localparam int WMASK_LENGTH   = 2;
    localparam int ROPCODE_LENGTH = 3;

    localparam logic [WMASK_LENGTH-1:0] WRITE_BYTE = 2'd1;
    localparam logic [WMASK_LENGTH-1:0] WRITE_HALF = 2'd2;
    localparam logic [WMASK_LENGTH-1:0] WRITE_WORD = 2'd3;

    localparam logic [ROPCODE_LENGTH-1:0] READ_WORD  = 3'd1;
    localparam logic [ROPCODE_LENGTH-1:0] READ_HALF  = 3'd2;
    localparam logic [ROPCODE_LENGTH-1:0] READ_BYTE  = 3'd3;
    localparam logic [ROPCODE_LENGTH-1:0] READ_HALFU = 3'd4;
    localparam logic [ROPCODE_LENGTH-1:0] READ_BYTEU = 3'd5;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_RSP  = 2'd2,
        LSU_DONE = 2'd3
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_e;

    // An absent or unknown code falls back to a full word access.
    function automatic size_e store_size(input logic [WMASK_LENGTH-1:0] wm);
        case (wm)
            WRITE_BYTE: return SZ_BYTE;
            WRITE_HALF: return SZ_HALF;
            default:    return SZ_WORD;
        endcase
    endfunction

    function automatic size_e load_size(input logic [ROPCODE_LENGTH-1:0] rop);
        case (rop)
            READ_BYTE, READ_BYTEU: return SZ_BYTE;
            READ_HALF, READ_HALFU: return SZ_HALF;
            default:               return SZ_WORD;
        endcase
    endfunction

    function automatic logic load_signed(input logic [ROPCODE_LENGTH-1:0] rop);
        return (rop == READ_BYTE) || (rop == READ_HALF);
    endfunction

endpackage

// File: rtl/ysyx_23060184_lsu_align.sv
// Byte-lane logic for the LSU: store strobe/data replication, misalignment check on the
// incoming instruction, and load shift plus sign/zero extension on the returned word.
module ysyx_23060184_lsu_align
    import ysyx_23060184_lsu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [1:0]                addr_lo,
    input  logic                      mem_read,
    input  logic                      mem_write,
    input  logic [WMASK_LENGTH-1:0]   wmask,
    input  logic [ROPCODE_LENGTH-1:0] ropcode,
    input  logic [DATA_W-1:0]         store_data,
    output logic [3:0]                wstrb,
    output logic [DATA_W-1:0]         wdata,
    output logic                      misaligned,
    input  logic [1:0]                ld_addr_lo,
    input  logic [ROPCODE_LENGTH-1:0] ld_ropcode,
    input  logic [DATA_W-1:0]         rdata,
    output logic [DATA_W-1:0]         ldata
);

    size_e              st_size;
    size_e              acc_size;
    logic [DATA_W-1:0]  shifted;
    logic signed [7:0]  sbyte;
    logic signed [15:0] shalf;

    always_comb begin
        st_size  = store_size(wmask);
        // A store wins when both read and write are flagged.
        acc_size = mem_write ? st_size : load_size(ropcode);
        misaligned = (mem_read || mem_write) &&
                     (((acc_size == SZ_HALF) && addr_lo[0]) ||
                      ((acc_size == SZ_WORD) && (addr_lo != 2'b00)));

        wstrb = 4'b0000;
        wdata = store_data;
        if (mem_write) begin
            case (st_size)
                SZ_BYTE: begin
                    wstrb = 4'b0001 << addr_lo;
                    wdata = {4{store_data[7:0]}};
                end
                SZ_HALF: begin
                    wstrb = 4'b0011 << addr_lo;
                    wdata = {2{store_data[15:0]}};
                end
                default: wstrb = 4'b1111;
            endcase
        end
    end

    always_comb begin
        shifted = rdata >> {ld_addr_lo, 3'b000};
        sbyte   = shifted[7:0];
        shalf   = shifted[15:0];
        case (load_size(ld_ropcode))
            SZ_BYTE: ldata = load_signed(ld_ropcode) ? DATA_W'(sbyte) : DATA_W'(shifted[7:0]);
            SZ_HALF: ldata = load_signed(ld_ropcode) ? DATA_W'(shalf) : DATA_W'(shifted[15:0]);
            default: ldata = shifted;
        endcase
    end

endmodule

// File: rtl/ysyx_23060184_lsu.sv
// Load/store unit: one memory transaction per instruction over valid/ready request and
// response channels; non-memory results pass straight through to writeback.
module ysyx_23060184_lsu
    import ysyx_23060184_lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      MemRead,
    input  logic                      MemWrite,
    input  logic [WMASK_LENGTH-1:0]   Wmask,
    input  logic [ROPCODE_LENGTH-1:0] Ropcode,
    input  logic [ADDR_W-1:0]         alu_result,
    input  logic [DATA_W-1:0]         store_data,
    output logic                      req_valid,
    input  logic                      req_ready,
    output logic [ADDR_W-1:0]         req_addr,
    output logic                      req_wen,
    output logic [DATA_W-1:0]         req_wdata,
    output logic [3:0]                req_wstrb,
    input  logic                      rsp_valid,
    output logic                      rsp_ready,
    input  logic [DATA_W-1:0]         rsp_rdata,
    input  logic                      rsp_err,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         out_data,
    output logic                      out_err
);

    lsu_state_e                state;
    logic [1:0]                ld_addr_lo;
    logic [ROPCODE_LENGTH-1:0] ld_ropcode;
    logic                      is_store;
    logic [3:0]                wstrb;
    logic [DATA_W-1:0]         wdata;
    logic                      misaligned;
    logic [DATA_W-1:0]         ldata;

    ysyx_23060184_lsu_align #(.DATA_W(DATA_W)) u_align (
        .addr_lo    (alu_result[1:0]),
        .mem_read   (MemRead),
        .mem_write  (MemWrite),
        .wmask      (Wmask),
        .ropcode    (Ropcode),
        .store_data (store_data),
        .wstrb      (wstrb),
        .wdata      (wdata),
        .misaligned (misaligned),
        .ld_addr_lo (ld_addr_lo),
        .ld_ropcode (ld_ropcode),
        .rdata      (rsp_rdata),
        .ldata      (ldata)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= LSU_IDLE;
            in_ready   <= 1'b1;
            req_valid  <= 1'b0;
            req_addr   <= '0;
            req_wen    <= 1'b0;
            req_wdata  <= '0;
            req_wstrb  <= 4'b0000;
            rsp_ready  <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_err    <= 1'b0;
            ld_addr_lo <= 2'b00;
            ld_ropcode <= '0;
            is_store   <= 1'b0;
        end else begin
            case (state)
                LSU_IDLE: if (in_valid) begin
                    in_ready   <= 1'b0;
                    ld_addr_lo <= alu_result[1:0];
                    ld_ropcode <= Ropcode;
                    is_store   <= MemWrite;
                    if (!MemRead && !MemWrite) begin
                        out_data  <= DATA_W'(alu_result);
                        out_err   <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= LSU_DONE;
                    end else if (misaligned) begin
                        out_data  <= '0;
                        out_err   <= 1'b1;
                        out_valid <= 1'b1;
                        state     <= LSU_DONE;
                    end else begin
                        req_valid <= 1'b1;
                        req_addr  <= {alu_result[ADDR_W-1:2], 2'b00};
                        req_wen   <= MemWrite;
                        req_wdata <= wdata;
                        req_wstrb <= wstrb;
                        state     <= LSU_REQ;
                    end
                end
                LSU_REQ: if (req_ready) begin
                    req_valid <= 1'b0;
                    rsp_ready <= 1'b1;
                    state     <= LSU_RSP;
                end
                LSU_RSP: if (rsp_valid) begin
                    rsp_ready <= 1'b0;
                    out_data  <= is_store ? '0 : ldata;
                    out_err   <= rsp_err;
                    out_valid <= 1'b1;
                    state     <= LSU_DONE;
                end
                LSU_DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= LSU_IDLE;
                end
                default: state <= LSU_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_23060184_lsu.sv
// Directed and randomized checks of the LSU against a byte-lane arithmetic model.
module tb_ysyx_23060184_lsu;

    logic        clk = 1'b0;
    logic        rstn;
    logic        in_valid;
    logic        in_ready;
    logic        MemRead;
    logic        MemWrite;
    logic [1:0]  Wmask;
    logic [2:0]  Ropcode;
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_wen;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_err;

    int tests = 0;
    int fails = 0;

    ysyx_23060184_lsu dut (
        .clk(clk), .rstn(rstn),
        .in_valid(in_valid), .in_ready(in_ready),
        .MemRead(MemRead), .MemWrite(MemWrite), .Wmask(Wmask), .Ropcode(Ropcode),
        .alu_result(alu_result), .store_data(store_data),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_wen(req_wen), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err)
    );

    always #5 clk = ~clk;

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // kind: 0 non-memory, 1 load, 2 store. Sizes in bytes, lanes filled by modulo.
    function automatic void model(input logic rd, input logic wr, input logic [1:0] wm,
                                  input logic [2:0] rop, input logic [31:0] addr,
                                  input logic [31:0] sd, input logic [31:0] rdata,
                                  output int kind, output bit mis, output logic [3:0] strb,
                                  output logic [31:0] wdata, output logic [31:0] ldata);
        int     n;
        int     a;
        bit     sgn;
        longint v;
        a    = int'(addr[1:0]);
        kind = wr ? 2 : (rd ? 1 : 0);
        sgn  = 0;
        if (kind == 2) n = (wm == 2'd1) ? 1 : (wm == 2'd2) ? 2 : 4;
        else begin
            n   = (rop == 3'd3 || rop == 3'd5) ? 1 : (rop == 3'd2 || rop == 3'd4) ? 2 : 4;
            sgn = (rop == 3'd2 || rop == 3'd3);
        end
        mis  = (kind != 0) && ((n == 2 && (a % 2) != 0) || (n == 4 && a != 0));
        strb = (kind == 2) ? 4'(((1 << n) - 1) << a) : 4'd0;
        for (int i = 0; i < 4; i++) wdata[8*i +: 8] = sd[8*(i % n) +: 8];
        v = (longint'(rdata) >> (8 * a)) & ((longint'(1) << (8 * n)) - 1);
        if (sgn && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
        ldata = v[31:0];
    endfunction

    task automatic run_op(input logic rd, input logic wr, input logic [1:0] wm,
                          input logic [2:0] rop, input logic [31:0] addr, input logic [31:0] sd,
                          input logic [31:0] rdata, input logic err,
                          input int rqw, input int rsw, input int ow);
        int          kind;
        bit          mis;
        logic [3:0]  e_strb;
        logic [31:0] e_wdata, e_ldata, e_out;
        logic        e_err;
        model(rd, wr, wm, rop, addr, sd, rdata, kind, mis, e_strb, e_wdata, e_ldata);
        @(negedge clk);
        chk1("in_ready_idle", in_ready, 1'b1);
        in_valid = 1'b1; MemRead = rd; MemWrite = wr; Wmask = wm; Ropcode = rop;
        alu_result = addr; store_data = sd; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0; MemRead = 1'($urandom); MemWrite = 1'($urandom);
        Wmask = 2'($urandom); Ropcode = 3'($urandom); alu_result = $urandom; store_data = $urandom;
        chk1("in_ready_busy", in_ready, 1'b0);
        if (kind == 0 || mis) begin
            e_out = (kind == 0) ? addr : 32'd0;
            e_err = mis;
            chk1("req_valid_none", req_valid, 1'b0);
            chk1("out_valid_fast", out_valid, 1'b1);
        end else begin
            e_out = (kind == 2) ? 32'd0 : e_ldata;
            e_err = err;
            chk1("req_valid", req_valid, 1'b1);
            chk32("req_addr", req_addr, {addr[31:2], 2'b00});
            chk1("req_wen", req_wen, kind == 2);
            chk32("req_wstrb", {28'd0, req_wstrb}, {28'd0, e_strb});
            if (kind == 2) chk32("req_wdata", req_wdata, e_wdata);
            for (int i = 0; i < rqw; i++) begin
                rsp_valid = 1'($urandom);
                @(negedge clk);
                chk1("req_valid_hold", req_valid, 1'b1);
                chk32("req_addr_hold", req_addr, {addr[31:2], 2'b00});
                chk32("req_wstrb_hold", {28'd0, req_wstrb}, {28'd0, e_strb});
                if (kind == 2) chk32("req_wdata_hold", req_wdata, e_wdata);
            end
            rsp_valid = 1'b0;
            req_ready = 1'b1;
            @(negedge clk);
            req_ready = 1'b0;
            chk1("req_valid_drop", req_valid, 1'b0);
            chk1("rsp_ready", rsp_ready, 1'b1);
            for (int i = 0; i < rsw; i++) begin
                @(negedge clk);
                chk1("rsp_ready_hold", rsp_ready, 1'b1);
                chk1("out_valid_wait", out_valid, 1'b0);
            end
            rsp_valid = 1'b1; rsp_rdata = rdata; rsp_err = err;
            @(negedge clk);
            rsp_valid = 1'b0; rsp_rdata = $urandom; rsp_err = 1'b0;
            chk1("out_valid", out_valid, 1'b1);
            chk1("rsp_ready_drop", rsp_ready, 1'b0);
        end
        chk32("out_data", out_data, e_out);
        chk1("out_err", out_err, e_err);
        for (int i = 0; i < ow; i++) begin
            @(negedge clk);
            chk1("out_valid_hold", out_valid, 1'b1);
            chk32("out_data_hold", out_data, e_out);
            chk1("in_ready_hold", in_ready, 1'b0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk1("out_valid_done", out_valid, 1'b0);
        chk1("in_ready_back", in_ready, 1'b1);
    endtask

    initial begin
        rstn = 1'b0; in_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; Wmask = 2'd0;
        Ropcode = 3'd0; alu_result = 32'd0; store_data = 32'd0; req_ready = 1'b0;
        rsp_valid = 1'b0; rsp_rdata = 32'd0; rsp_err = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk1("rst_in_ready", in_ready, 1'b1);
        chk1("rst_req_valid", req_valid, 1'b0);
        chk1("rst_rsp_ready", rsp_ready, 1'b0);
        chk1("rst_out_valid", out_valid, 1'b0);
        chk32("rst_out_data", out_data, 32'd0);
        chk1("rst_out_err", out_err, 1'b0);
        rstn = 1'b1;

        // non-memory pass-through, then sb / lb / lbu / lh / misaligned lw
        run_op(1'b0, 1'b0, 2'd0, 3'd0, 32'h0000_1234, 32'h0, 32'h0, 1'b0, 0, 0, 0);
        run_op(1'b0, 1'b1, 2'd1, 3'd0, 32'h8000_0003, 32'hAABB_CCDD, 32'h0, 1'b0, 0, 0, 0);
        chk32("sb_wstrb_direct", {28'd0, req_wstrb}, 32'h8);
        chk32("sb_wdata_direct", req_wdata, 32'hDDDD_DDDD);
        run_op(1'b1, 1'b0, 2'd0, 3'd3, 32'h8000_0002, 32'h0, 32'h00F0_0000, 1'b0, 0, 0, 0);
        chk32("lb_direct", out_data, 32'hFFFF_FFF0);
        run_op(1'b1, 1'b0, 2'd0, 3'd5, 32'h8000_0002, 32'h0, 32'h00F0_0000, 1'b0, 0, 0, 0);
        chk32("lbu_direct", out_data, 32'h0000_00F0);
        run_op(1'b1, 1'b0, 2'd0, 3'd2, 32'h8000_0002, 32'h0, 32'h8000_0000, 1'b0, 0, 0, 0);
        chk32("lh_direct", out_data, 32'hFFFF_8000);
        run_op(1'b1, 1'b0, 2'd0, 3'd1, 32'h8000_0001, 32'h0, 32'h0, 1'b0, 0, 0, 0);
        chk1("lw_mis_err", out_err, 1'b1);

        // backpressure on every channel, bus error, illegal combinations
        run_op(1'b0, 1'b1, 2'd3, 3'd0, 32'h8000_0010, 32'h1234_5678, 32'h0, 1'b0, 5, 3, 4);
        run_op(1'b1, 1'b0, 2'd0, 3'd1, 32'h8000_0020, 32'h0, 32'hCAFE_F00D, 1'b1, 2, 1, 2);
        run_op(1'b1, 1'b1, 2'd2, 3'd1, 32'h8000_0022, 32'h0000_BEEF, 32'h0, 1'b0, 1, 0, 1);
        run_op(1'b1, 1'b0, 2'd0, 3'd0, 32'h8000_0024, 32'h0, 32'h8765_4321, 1'b0, 0, 0, 0);
        run_op(1'b0, 1'b1, 2'd0, 3'd0, 32'h8000_0028, 32'h0102_0304, 32'h0, 1'b0, 0, 0, 0);

        // reset while waiting for the response
        @(negedge clk);
        in_valid = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; Ropcode = 3'd1;
        alu_result = 32'h8000_0100; req_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        req_ready = 1'b0;
        chk1("mid_rsp_ready", rsp_ready, 1'b1);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        chk1("mid_rst_in_ready", in_ready, 1'b1);
        chk1("mid_rst_rsp_ready", rsp_ready, 1'b0);
        chk1("mid_rst_req_valid", req_valid, 1'b0);
        chk1("mid_rst_out_valid", out_valid, 1'b0);
        chk32("mid_rst_out_data", out_data, 32'd0);
        rsp_valid = 1'b1; rsp_rdata = 32'h5555_AAAA;
        @(negedge clk);
        rsp_valid = 1'b0;
        chk1("late_rsp_ignored", out_valid, 1'b0);
        @(negedge clk);
        chk1("late_rsp_ignored2", out_valid, 1'b0);

        for (int t = 0; t < 60; t++) begin
            int k;
            k = $urandom_range(0, 3);
            run_op(k[0], k[1], 2'($urandom_range(0, 3)), 3'($urandom_range(0, 5)),
                   $urandom, $urandom, $urandom, 1'($urandom_range(0, 4) == 0),
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
